dispense_arbiter: RTL and testbench
===================================

DISPENSE_ARBITER -- requirements
Module: dispense_arbiter

Interface
REQ-001 SHALL have parameter REQUESTER_COUNT, default 4, number of dispenser front-ends sharing one pump/valve.
REQ-002 SHALL have parameter NS_PER_ML, default 100, pump time per millilitre in ns.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, valve-open-to-pump-on delay in clock cycles (>=1).
REQ-004 SHALL have port clock, input, 1, sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-006 SHALL have port request, input, REQUESTER_COUNT, level request per requester.
REQ-007 SHALL have port amount_in_ml, input, REQUESTER_COUNT*14, requester k volume in bits [14k+13:14k].
REQ-008 SHALL have port cancel, input, REQUESTER_COUNT, single-cycle abort pulse per requester.
REQ-009 SHALL have port grant, output, REQUESTER_COUNT, one-hot owner of the pump, or all zero.
REQ-010 SHALL have port valve_open, output, 1, valve drive.
REQ-011 SHALL have port pump_on, output, 1, pump drive.
REQ-012 SHALL have port remaining_in_ml, output, 14, volume still to dispense for the current grant.
REQ-013 SHALL have port done, output, REQUESTER_COUNT, one-cycle completion pulse to the owner.
REQ-014 SHALL have port aborted, output, 1, qualifies done: 1 = ended by cancel.

Function
REQ-015 SHALL implement states IDLE, SETTLE, DISPENSING, FINISH.
REQ-016 IDLE: requesters eligible only if request=1 and amount nonzero; with none eligible SHALL stay IDLE.
REQ-017 IDLE: SHALL pick the eligible requester by round-robin, starting at last_granted+1 modulo REQUESTER_COUNT; last_granted resets to REQUESTER_COUNT-1, so requester 0 has first priority.
REQ-018 On pick, SHALL latch the amount, saturated to 9999, into remaining_in_ml; assert grant and valve_open on the next edge; enter SETTLE.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles with valve_open=1 and pump_on=0, then enter DISPENSING.
REQ-020 DISPENSING SHALL hold pump_on=1 and valve_open=1, and decrement remaining_in_ml once every TICKS_PER_ML = NS_PER_ML/20 cycles.
REQ-021 When remaining_in_ml reaches 0, SHALL enter FINISH on that edge; pump_on is thus high for exactly amount*TICKS_PER_ML cycles.
REQ-022 FINISH SHALL last one cycle: done[owner]=1, grant kept, pump_on=0, valve_open=0; then IDLE with last_granted=owner and grant cleared.
REQ-023 cancel[owner] in SETTLE or DISPENSING SHALL enter FINISH on the next edge with aborted=1 and remaining_in_ml frozen; otherwise aborted=0 in FINISH.
REQ-024 Cancel and the final decrement in the same cycle: cancel SHALL win (aborted=1, remaining_in_ml=1).
REQ-025 cancel from a non-owner, and cancel in IDLE, SHALL be ignored.
REQ-026 Request deassertion by the owner, and amount changes after latch, SHALL be ignored.
REQ-027 A new grant SHALL never start in the FINISH cycle; there is at least one IDLE cycle between grants.

Reset
REQ-028 Reset SHALL immediately force IDLE, grant=0, valve_open=0, pump_on=0, done=0, aborted=0, remaining_in_ml=0, tick count 0, and last_granted=REQUESTER_COUNT-1, including mid-dispense.

Structure
REQ-029 CLOCK_PERIOD_IN_NS=20, MAXIMUM_VOLUME_IN_ML=9999, VOLUME_BIT_COUNT=14 and the state encoding SHALL live in shared package water_dispenser_pkg.
REQ-030 Per-millilitre tick generation SHALL be sub-module ml_tick_timer (enable, clear, one-cycle tick output every TICKS_PER_ML cycles).
REQ-031 Elaboration SHALL fail if NS_PER_ML is not a positive multiple of 20.

Verification (defaults, TICKS_PER_ML=5, SETTLE_CYCLES=4)
REQ-032 request[1]=1, amount 3 -> grant=0010 next edge; SETTLE 4 cycles; pump_on 15 cycles; remaining 3,2,1,0; done[1] one pulse, aborted=0.
REQ-033 After a grant to requester 0, requests 0 and 2 together -> requester 2 is served first, then requester 0.
REQ-034 Requester 3 amount 10, cancel[3] on 7th pump cycle -> FINISH next edge, done[3]=1, aborted=1, remaining_in_ml=9; cancel[0] in the same run is ignored.
REQ-035 Amount 0 with request=1 -> no grant; amount 12000 -> latched remaining_in_ml=9999.
REQ-036 Reset asserted mid-DISPENSING -> pump_on, valve_open, grant all 0 without waiting for a clock edge; then requester 0 wins the next tie.

Source files
------------

// File: rtl/water_dispenser_pkg.sv
// Shared definitions for the water dispenser: clock period, volume limits,
// the arbiter state encoding and a volume saturation helper.
package water_dispenser_pkg;

    localparam int CLOCK_PERIOD_IN_NS   = 20;
    localparam int MAXIMUM_VOLUME_IN_ML = 9999;
    localparam int VOLUME_BIT_COUNT     = 14;

    typedef logic [VOLUME_BIT_COUNT-1:0] volume_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SETTLE     = 2'd1,
        DISPENSING = 2'd2,
        FINISH     = 2'd3
    } dispense_state_t;

    // Clamp a requested volume to what one dispense is allowed to deliver.
    function automatic volume_t saturate_volume(input volume_t requested);
        if (requested > volume_t'(MAXIMUM_VOLUME_IN_ML)) begin
            return volume_t'(MAXIMUM_VOLUME_IN_ML);
        end
        return requested;
    endfunction

endpackage

// File: rtl/ml_tick_timer.sv
// Per-millilitre tick generator: while enabled, emits a one-cycle tick every
// TICKS_PER_ML cycles; clear restarts the count from zero.
module ml_tick_timer #(
    parameter int TICKS_PER_ML = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int COUNT_WIDTH = (TICKS_PER_ML > 1) ? $clog2(TICKS_PER_ML) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(TICKS_PER_ML - 1);

    logic [COUNT_WIDTH-1:0] count;

    assign tick = enable && !clear && (count == LAST_COUNT);

    // Cycle counter that wraps after each completed millilitre.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values and simulation matches the synthesized registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST_COUNT) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/dispense_arbiter.sv
// Round-robin arbiter sharing one pump/valve between several dispenser
// front-ends: grants one requester, settles the valve, pumps the latched
// volume one millilitre per tick, then pulses done to the owner.
module dispense_arbiter
    import water_dispenser_pkg::*;
#(
    parameter int REQUESTER_COUNT = 4,
    parameter int NS_PER_ML       = 100,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [REQUESTER_COUNT-1:0]                request,
    input  logic [REQUESTER_COUNT*VOLUME_BIT_COUNT-1:0] amount_in_ml,
    input  logic [REQUESTER_COUNT-1:0]                cancel,
    output logic [REQUESTER_COUNT-1:0]                grant,
    output logic                                      valve_open,
    output logic                                      pump_on,
    output logic [VOLUME_BIT_COUNT-1:0]               remaining_in_ml,
    output logic [REQUESTER_COUNT-1:0]                done,
    output logic                                      aborted
);

    localparam int TICKS_PER_ML = NS_PER_ML / CLOCK_PERIOD_IN_NS;
    localparam int INDEX_WIDTH  = (REQUESTER_COUNT > 1) ? $clog2(REQUESTER_COUNT) : 1;
    localparam int SETTLE_WIDTH = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [INDEX_WIDTH-1:0]  LAST_REQUESTER = INDEX_WIDTH'(REQUESTER_COUNT - 1);
    localparam logic [SETTLE_WIDTH-1:0] LAST_SETTLE    = SETTLE_WIDTH'(SETTLE_CYCLES - 1);

    // Reject pump rates that do not map onto a whole number of clock cycles.
    generate
        if (NS_PER_ML <= 0 || (NS_PER_ML % CLOCK_PERIOD_IN_NS) != 0) begin : g_bad_ns_per_ml
            $error("NS_PER_ML must be a positive multiple of the clock period");
        end
        if (SETTLE_CYCLES < 1) begin : g_bad_settle_cycles
            $error("SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    dispense_state_t            state, state_next;
    volume_t                    remaining, remaining_next;
    logic [REQUESTER_COUNT-1:0] grant_q, grant_next;
    logic [INDEX_WIDTH-1:0]     owner, owner_next;
    logic [INDEX_WIDTH-1:0]     last_granted, last_granted_next;
    logic [SETTLE_WIDTH-1:0]    settle_count, settle_count_next;
    logic                       aborted_q, aborted_next;

    volume_t                    amount_of [REQUESTER_COUNT];
    logic [REQUESTER_COUNT-1:0] eligible;
    logic [INDEX_WIDTH-1:0]     candidate;
    logic [INDEX_WIDTH-1:0]     pick_index;
    logic                       pick_found;
    logic                       owner_cancel;
    logic                       ml_tick;

    // A requester competes only with a live request and a nonzero volume.
    for (genvar g = 0; g < REQUESTER_COUNT; g++) begin : g_requester
        assign amount_of[g] = amount_in_ml[g*VOLUME_BIT_COUNT +: VOLUME_BIT_COUNT];
        assign eligible[g]  = request[g] && (amount_of[g] != '0);
    end

    assign owner_cancel = |(cancel & grant_q);

    ml_tick_timer #(
        .TICKS_PER_ML (TICKS_PER_ML)
    ) u_ml_tick_timer (
        .clock  (clock),
        .reset  (reset),
        .enable (state == DISPENSING),
        .clear  (state != DISPENSING),
        .tick   (ml_tick)
    );

    // Round-robin search starting just after the last requester served.
    // NOTE: every signal written in a combinational block gets a default at
    // the top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        pick_found = 1'b0;
        pick_index = '0;
        candidate  = '0;
        for (int offset = 1; offset <= REQUESTER_COUNT; offset++) begin
            candidate = INDEX_WIDTH'((int'(last_granted) + offset) % REQUESTER_COUNT);
            if (!pick_found && eligible[candidate]) begin
                pick_found = 1'b1;
                pick_index = candidate;
            end
        end
    end

    // Next-state logic, datapath updates and pump/valve outputs per state.
    always_comb begin
        state_next        = state;
        remaining_next    = remaining;
        grant_next        = grant_q;
        owner_next        = owner;
        last_granted_next = last_granted;
        settle_count_next = settle_count;
        aborted_next      = 1'b0;
        valve_open        = 1'b0;
        pump_on           = 1'b0;
        done              = '0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_next             = '0;
                    grant_next[pick_index] = 1'b1;
                    owner_next             = pick_index;
                    remaining_next         = saturate_volume(amount_of[pick_index]);
                    settle_count_next      = '0;
                    state_next             = SETTLE;
                end
            end
            SETTLE: begin
                valve_open = 1'b1;
                if (owner_cancel) begin
                    aborted_next = 1'b1;
                    state_next   = FINISH;
                end else if (settle_count == LAST_SETTLE) begin
                    state_next = DISPENSING;
                end else begin
                    settle_count_next = settle_count + 1'b1;
                end
            end
            DISPENSING: begin
                valve_open = 1'b1;
                pump_on    = 1'b1;
                // A cancel takes priority over a decrement landing on the same edge.
                if (owner_cancel) begin
                    aborted_next = 1'b1;
                    state_next   = FINISH;
                end else if (ml_tick) begin
                    remaining_next = remaining - 1'b1;
                    if (remaining == volume_t'(1)) begin
                        state_next = FINISH;
                    end
                end
            end
            FINISH: begin
                done              = grant_q;
                aborted_next      = 1'b0;
                grant_next        = '0;
                last_granted_next = owner;
                state_next        = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant, owner bookkeeping, settle counter, volume and abort flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining    <= '0;
            grant_q      <= '0;
            owner        <= '0;
            last_granted <= LAST_REQUESTER;
            settle_count <= '0;
            aborted_q    <= 1'b0;
        end else begin
            remaining    <= remaining_next;
            grant_q      <= grant_next;
            owner        <= owner_next;
            last_granted <= last_granted_next;
            settle_count <= settle_count_next;
            aborted_q    <= aborted_next;
        end
    end

    assign grant           = grant_q;
    assign remaining_in_ml = remaining;
    assign aborted         = aborted_q;

endmodule

// File: tb/tb_dispense_arbiter.sv
// Scoreboard bench for dispense_arbiter: stimulus pushes the expected
// completion of each grant; a monitor pops and compares on every done pulse.
module tb_dispense_arbiter;

    localparam int N = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    request;
    logic [N*14-1:0] amount_in_ml;
    logic [N-1:0]    cancel;
    logic [N-1:0]    grant;
    logic            valve_open;
    logic            pump_on;
    logic [13:0]     remaining_in_ml;
    logic [N-1:0]    done;
    logic            aborted;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int owner;
        int aborted;
        int remaining;
        int pump_cycles;
        int settle_cycles;
    } expect_t;

    expect_t exp_q[$];
    expect_t mon_e;
    int      pump_seen   = 0;
    int      settle_seen = 0;

    always #5 clock = ~clock;

    dispense_arbiter dut (
        .clock           (clock),
        .reset           (reset),
        .request         (request),
        .amount_in_ml    (amount_in_ml),
        .cancel          (cancel),
        .grant           (grant),
        .valve_open      (valve_open),
        .pump_on         (pump_on),
        .remaining_in_ml (remaining_in_ml),
        .done            (done),
        .aborted         (aborted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_done(input int owner, input int ab, input int rem,
                               input int pump, input int settle);
        expect_t e;
        e.owner         = owner;
        e.aborted       = ab;
        e.remaining     = rem;
        e.pump_cycles   = pump;
        e.settle_cycles = settle;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int idx, input logic on, input int amt);
        request[idx]                = on;
        amount_in_ml[idx*14 +: 14] = 14'(amt);
    endtask

    task automatic wait_grant(input logic [N-1:0] g);
        int n = 0;
        while (grant !== g && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("grant_wait", 32'(grant), 32'(g));
    endtask

    task automatic wait_pump();
        int n = 0;
        while (pump_on !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("pump_wait", 32'(pump_on), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (grant !== '0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("idle_wait", 32'(grant), 32'd0);
        @(negedge clock);
    endtask

    // Monitor: count settle/pump cycles and score every completion pulse.
    always @(negedge clock) begin
        if (reset) begin
            pump_seen   = 0;
            settle_seen = 0;
        end else begin
            if (pump_on) pump_seen++;
            if (valve_open && !pump_on) settle_seen++;
            if (done !== '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_owner",    32'(done),            32'(1 << mon_e.owner));
                    check("grant_held",    32'(grant),           32'(1 << mon_e.owner));
                    check("aborted",       32'(aborted),         32'(mon_e.aborted));
                    check("remaining",     32'(remaining_in_ml), 32'(mon_e.remaining));
                    check("pump_cycles",   32'(pump_seen),       32'(mon_e.pump_cycles));
                    check("settle_cycles", 32'(settle_seen),     32'(mon_e.settle_cycles));
                    check("finish_valve",  32'(valve_open),      32'd0);
                    check("finish_pump",   32'(pump_on),         32'd0);
                end
                pump_seen   = 0;
                settle_seen = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        request      = '0;
        cancel       = '0;
        amount_in_ml = '0;
        #3;
        check("reset_grant",     32'(grant),           32'd0);
        check("reset_valve",     32'(valve_open),      32'd0);
        check("reset_pump",      32'(pump_on),         32'd0);
        check("reset_done",      32'(done),            32'd0);
        check("reset_aborted",   32'(aborted),         32'd0);
        check("reset_remaining", 32'(remaining_in_ml), 32'd0);
        @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);

        // Cancel pulses while idle change nothing.
        cancel = '1;
        @(negedge clock);
        cancel = '0;
        check("idle_cancel_grant", 32'(grant), 32'd0);

        // Requester 1, 3 ml: grant next edge, then owner withdraws and edits amount.
        expect_done(1, 0, 0, 15, 4);
        set_req(1, 1'b1, 3);
        @(negedge clock);
        check("first_grant",     32'(grant),           32'b0010);
        check("first_remaining", 32'(remaining_in_ml), 32'd3);
        check("first_valve",     32'(valve_open),      32'd1);
        check("first_pump",      32'(pump_on),         32'd0);
        set_req(1, 1'b0, 7);
        wait_idle();

        // Serve requester 0, then a 0+2 tie must go to 2 first.
        expect_done(0, 0, 0, 5, 4);
        set_req(0, 1'b1, 1);
        wait_grant(4'b0001);
        set_req(0, 1'b0, 0);
        wait_idle();
        expect_done(2, 0, 0, 10, 4);
        expect_done(0, 0, 0, 10, 4);
        set_req(0, 1'b1, 2);
        set_req(2, 1'b1, 2);
        wait_grant(4'b0100);
        set_req(2, 1'b0, 0);
        wait_grant(4'b0001);
        set_req(0, 1'b0, 0);
        wait_idle();

        // Requester 3, 10 ml: non-owner cancel on pump cycle 3, owner cancel on 7.
        expect_done(3, 1, 9, 7, 4);
        set_req(3, 1'b1, 10);
        wait_grant(4'b1000);
        set_req(3, 1'b0, 10);
        wait_pump();
        repeat (2) @(negedge clock);
        cancel = 4'b0001;
        @(negedge clock);
        cancel = '0;
        repeat (3) @(negedge clock);
        cancel = 4'b1000;
        @(negedge clock);
        cancel = '0;
        wait_idle();

        // Cancel coinciding with the final decrement: cancel wins, 1 ml left.
        expect_done(2, 1, 1, 5, 4);
        set_req(2, 1'b1, 1);
        wait_grant(4'b0100);
        set_req(2, 1'b0, 0);
        wait_pump();
        repeat (4) @(negedge clock);
        cancel = 4'b0100;
        @(negedge clock);
        cancel = '0;
        wait_idle();

        // Zero volume never wins; an oversized volume saturates to 9999.
        set_req(0, 1'b1, 0);
        repeat (5) @(negedge clock);
        check("zero_amount_grant", 32'(grant),      32'd0);
        check("zero_amount_valve", 32'(valve_open), 32'd0);
        expect_done(0, 1, 9999, 0, 2);
        set_req(0, 1'b1, 12000);
        @(negedge clock);
        check("saturated_grant",     32'(grant),           32'b0001);
        check("saturated_remaining", 32'(remaining_in_ml), 32'd9999);
        set_req(0, 1'b0, 0);
        @(negedge clock);
        cancel = 4'b0001;
        @(negedge clock);
        cancel = '0;
        wait_idle();

        // Reset mid-dispense drops everything before any clock edge.
        set_req(1, 1'b1, 20);
        wait_grant(4'b0010);
        set_req(1, 1'b0, 0);
        wait_pump();
        repeat (3) @(negedge clock);
        #3 reset = 1'b1;
        #1;
        check("midreset_pump",      32'(pump_on),         32'd0);
        check("midreset_valve",     32'(valve_open),      32'd0);
        check("midreset_grant",     32'(grant),           32'd0);
        check("midreset_remaining", 32'(remaining_in_ml), 32'd0);
        @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);

        // After reset requester 0 has first priority in a 0+3 tie.
        expect_done(0, 0, 0, 5, 4);
        expect_done(3, 0, 0, 5, 4);
        set_req(0, 1'b1, 1);
        set_req(3, 1'b1, 1);
        wait_grant(4'b0001);
        set_req(0, 1'b0, 0);
        wait_grant(4'b1000);
        set_req(3, 1'b0, 0);
        wait_idle();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
